// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / taken-branch / mult-div sequencing for the 5-stage core; stall and flush are combinational (0 cycles); optional HZ_STALL_CNT_EN stall counter.
// Backpressure: a stall drops pc_write/ifid_write and bubbles ID/EX until the hazard clears; a flush overrides a stall.
module hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MUL_CYC = 4,
  parameter int DIV_CYC = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_hz_id_rs,
  input  logic [REG_AW-1:0] i_hz_id_rt,
  input  logic              i_hz_id_uses_rt,
  input  logic [REG_AW-1:0] i_hz_ex_rt,
  input  logic              i_hz_ex_memread,
  input  logic              i_hz_br_taken,
  input  logic              i_hz_md_start,
  input  logic              i_hz_md_div,
  input  logic              i_hz_id_reads_hilo,
  output logic              o_hz_pc_write,
  output logic              o_hz_ifid_write,
  output logic              o_hz_bubble,
  output logic              o_hz_flush,
  output logic              o_hz_md_go,
  output logic              o_hz_md_busy,
  output logic              o_hz_md_done
`ifdef HZ_STALL_CNT_EN
  ,
  output logic [15:0]       o_hz_stall_cnt
`endif
);

  localparam int CW = $clog2(DIV_CYC + 1);
  localparam logic [CW-1:0] MUL_LD  = CW'(MUL_CYC - 1);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  md_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_use;
  logic            md_hold;
  logic            stall;
  logic            launch;

  // Register 0 is hardwired to zero, so a load into it never creates a dependency.
  always_comb begin
    load_use = i_hz_ex_memread && (i_hz_ex_rt != '0) &&
               ((i_hz_ex_rt == i_hz_id_rs) ||
                (i_hz_id_uses_rt && (i_hz_ex_rt == i_hz_id_rt)));
    md_hold  = (state_q != MD_IDLE) && (i_hz_id_reads_hilo || i_hz_md_start);
    stall    = load_use || md_hold;
  end

  always_comb begin
    o_hz_pc_write   = 1'b1;
    o_hz_ifid_write = 1'b1;
    o_hz_bubble     = 1'b0;
    o_hz_flush      = 1'b0;
    if (i_hz_br_taken) begin
      o_hz_flush = 1'b1;
    end else if (stall) begin
      o_hz_pc_write   = 1'b0;
      o_hz_ifid_write = 1'b0;
      o_hz_bubble     = 1'b1;
    end
  end

  // The counter is loaded with latency-1 so that md_done lands exactly latency cycles after md_go.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    launch  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (i_hz_md_start && !stall && !i_hz_br_taken) begin
          launch  = 1'b1;
          cnt_d   = i_hz_md_div ? DIV_LD : MUL_LD;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = MD_DONE;
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Launch is masked while reset is held so no pulse escapes during reset.
  assign o_hz_md_go   = launch && i_rst_n;
  assign o_hz_md_busy = (state_q != MD_IDLE);
  assign o_hz_md_done = (state_q == MD_DONE);

`ifdef HZ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && !i_hz_br_taken && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign o_hz_stall_cnt = stall_cnt_q;
`endif

endmodule
